// File: rtl/mic_dc_block_fifo.sv
// DC-blocking stage behind the I2S mic receiver: synchronises the bclk-domain valid,
// captures one sample per pulse, high-pass filters it (or bypasses) and queues it in a FWFT FIFO.
module mic_dc_block_fifo #(
   parameter int unsigned DC_SHIFT    = 6,
   parameter int unsigned FIFO_AW     = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [15:0]       sample_in,
   input  logic                     sample_in_valid,
   input  logic                     bypass,
   output logic signed [15:0]       out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [FIFO_AW:0]         fifo_level,
   output logic                     overflow,
   input  logic                     clr_overflow
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned LW    = FIFO_AW + 1;
   localparam logic signed [27:0] ACC_MAX = 28'sd8388352;
   localparam logic signed [27:0] ACC_MIN = -28'sd8388608;

   typedef enum logic [1:0] {IDLE, CALC, PUSH} state_t;

   state_t                   state;
   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     sync_prev_q;
   logic                     cap_q;
   logic signed [15:0]       x_q, x_prev_q, y_q;
   logic signed [23:0]       acc_q;

   logic signed [16:0]       diff_c;
   logic signed [27:0]       acc_ext_c, diff_ext_c, acc_n_c, acc_sat_c;

   logic signed [15:0]       mem [DEPTH];
   logic [FIFO_AW-1:0]       wr_q, rd_q, rd_next_c;
   logic [FIFO_AW:0]         level_next_c;
   logic signed [15:0]       push_data_c, head_next_c;
   logic                     push_c, pop_c, full_c, push_ok_c, ovf_set_c;

   // Valid synchroniser and registered rising-edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         sync_prev_q <= 1'b0;
         cap_q       <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], sample_in_valid};
         sync_prev_q <= sync_q[SYNC_STAGES-1];
         cap_q       <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
      end
   end

   // High-pass update in Q15.8, saturated to the 16-bit output range
   always_comb begin
      diff_c     = {x_q[15], x_q} - {x_prev_q[15], x_prev_q};
      acc_ext_c  = {{4{acc_q[23]}}, acc_q};
      diff_ext_c = {{11{diff_c[16]}}, diff_c};
      acc_n_c    = acc_ext_c + (diff_ext_c <<< 8) - (acc_ext_c >>> DC_SHIFT);
      acc_sat_c  = acc_n_c;
      if (acc_n_c > ACC_MAX)      acc_sat_c = ACC_MAX;
      else if (acc_n_c < ACC_MIN) acc_sat_c = ACC_MIN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         x_q      <= '0;
         x_prev_q <= '0;
         y_q      <= '0;
         acc_q    <= '0;
      end else begin
         unique case (state)
            IDLE: if (cap_q) begin
               x_q   <= sample_in;
               state <= CALC;
            end
            CALC: begin
               acc_q    <= acc_sat_c[23:0];
               y_q      <= acc_sat_c[23:8];
               x_prev_q <= x_q;
               state    <= PUSH;
            end
            PUSH:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO control; a full FIFO still accepts a push when it is popped in the same cycle
   always_comb begin
      push_c       = (state == PUSH);
      push_data_c  = bypass ? x_q : y_q;
      pop_c        = out_valid & out_ready;
      full_c       = (fifo_level == LW'(DEPTH));
      push_ok_c    = push_c & (~full_c | pop_c);
      rd_next_c    = pop_c ? rd_q + FIFO_AW'(1) : rd_q;
      level_next_c = fifo_level;
      if (push_ok_c && !pop_c)      level_next_c = fifo_level + LW'(1);
      else if (!push_ok_c && pop_c) level_next_c = fifo_level - LW'(1);
      head_next_c  = (push_ok_c && rd_next_c == wr_q) ? push_data_c : mem[rd_next_c];
      ovf_set_c    = (push_c & ~push_ok_c) | (cap_q & (state != IDLE));
   end

   always_ff @(posedge clk) begin
      if (push_ok_c) mem[wr_q] <= push_data_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q       <= '0;
         rd_q       <= '0;
         fifo_level <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok_c) wr_q <= wr_q + FIFO_AW'(1);
         rd_q       <= rd_next_c;
         fifo_level <= level_next_c;
         out_valid  <= (level_next_c != '0);
         if (level_next_c != '0) out_data <= head_next_c;
         if (ovf_set_c)         overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mic_dc_block_fifo.sv
// Directed bench for mic_dc_block_fifo: filter vector table plus latency, reset, overflow
// and full-with-pop sequences.
module tb_mic_dc_block_fifo;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [15:0] sample_in = '0;
   logic               sample_in_valid = 1'b0;
   logic               bypass = 1'b0;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [4:0]         fifo_level;
   logic               overflow;
   logic               clr_overflow = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   mic_dc_block_fifo #(.DC_SHIFT(6), .FIFO_AW(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_in_valid(sample_in_valid),
      .bypass(bypass), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fifo_level(fifo_level), .overflow(overflow), .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                 rst;
      bit                 bp;
      logic signed [15:0] s;
      logic signed [15:0] exp;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      sample_in_valid = 1'b0;
      out_ready = 1'b0;
      clr_overflow = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One valid pulse (4 clk high), then enough idle time for capture, filter and push
   task automatic pulse(input logic signed [15:0] s);
      @(posedge clk);
      #1 sample_in = s; sample_in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 sample_in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 16'sd1000,   16'sd1000};
      tbl[1] = '{1'b0, 1'b0, 16'sd1000,   16'sd984};
      tbl[2] = '{1'b0, 1'b0, 16'sd1000,   16'sd968};
      tbl[3] = '{1'b0, 1'b0, 16'sd1000,   16'sd953};
      tbl[4] = '{1'b1, 1'b0, -16'sd32768, -16'sd32768};
      tbl[5] = '{1'b0, 1'b0, 16'sd32767,  16'sd32767};
      tbl[6] = '{1'b0, 1'b0, -16'sd32768, -16'sd32768};
      tbl[7] = '{1'b1, 1'b1, 16'sh1234,   16'sh1234};
      tbl[8] = '{1'b0, 1'b0, 16'sh1234,   16'sd4587};
      tbl[9] = '{1'b0, 1'b1, -16'sd5,     -16'sd5};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_out_data", int'(out_data), 0);
      rst_n = 1'b1;

      // Filter vectors, consumer always ready so out_data holds the last popped sample
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].rst) do_reset();
         bypass = tbl[i].bp;
         out_ready = 1'b1;
         pulse(tbl[i].s);
         chk($sformatf("vec%0d_data", i), int'(out_data), int'(tbl[i].exp));
         chk($sformatf("vec%0d_empty", i), int'(out_valid), 0);
      end

      // Latency and single capture for a long valid pulse
      do_reset();
      bypass = 1'b1;
      @(posedge clk);
      #1 sample_in = 16'sh1234; sample_in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("lat_not_yet", int'(out_valid), 0);
      @(posedge clk);
      #1 chk("lat_valid", int'(out_valid), 1);
      chk("lat_data", int'(out_data), 'h1234);
      repeat (94) @(posedge clk);
      #1 sample_in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 chk("long_pulse_level", int'(fifo_level), 1);

      // Valid already high at reset release is captured exactly once
      #2 rst_n = 1'b0;
      sample_in = 16'sh0abc; sample_in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1 chk("rel_high_level", int'(fifo_level), 1);
      chk("rel_high_data", int'(out_data), 'h0abc);
      sample_in_valid = 1'b0;

      // Asynchronous reset with entries queued
      do_reset();
      bypass = 1'b1;
      for (int i = 0; i < 5; i++) pulse(16'(i + 10));
      chk("q5_level", int'(fifo_level), 5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", int'(out_valid), 0);
      chk("async_level", int'(fifo_level), 0);
      chk("async_overflow", int'(overflow), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      pulse(16'sd77);
      chk("post_rst_level", int'(fifo_level), 1);
      chk("post_rst_data", int'(out_data), 77);

      // Overflow: 17 pulses into a 16-deep FIFO, clear, then drain in order
      do_reset();
      bypass = 1'b1;
      for (int i = 1; i <= 17; i++) pulse(16'(i));
      chk("ovf_level", int'(fifo_level), 16);
      chk("ovf_flag", int'(overflow), 1);
      clr_overflow = 1'b1;
      @(posedge clk);
      #1 clr_overflow = 1'b0;
      chk("ovf_cleared", int'(overflow), 0);
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         chk($sformatf("drain%0d_valid", i), int'(out_valid), 1);
         chk($sformatf("drain%0d_data", i), int'(out_data), i);
         @(posedge clk);
         #1;
      end
      chk("drain_empty", int'(out_valid), 0);
      chk("drain_level", int'(fifo_level), 0);

      // Full FIFO, pop in the same cycle as the push
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) pulse(16'(100 + i));
      chk("full_level", int'(fifo_level), 16);
      @(posedge clk);
      #1 sample_in = 16'sd200; sample_in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 sample_in_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("fp_level", int'(fifo_level), 16);
      chk("fp_overflow", int'(overflow), 0);
      chk("fp_head", int'(out_data), 101);
      repeat (6) @(posedge clk);
      #1 out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("fp_drain%0d", i), int'(out_data), (i < 15) ? 101 + i : 200);
         @(posedge clk);
         #1;
      end
      chk("fp_empty", int'(out_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
